// File: rtl/div_if.sv
// Handshake and result bundle for the sequential signed divider.
// The master drives the request and operands. The slave returns registered results and status.
interface div_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic [2*WIDTH-1:0]   dividend_i;
  logic [WIDTH-1:0]     divisor_i;
  logic [WIDTH-1:0]     quotient_o;
  logic [WIDTH-1:0]     remainder_o;
  logic                 ovf_o;
  logic                 dz_o;
  logic                 done;
  logic                 busy;

  modport master (
    output start, dividend_i, divisor_i,
    input  quotient_o, remainder_o, ovf_o, dz_o, done, busy
  );

  modport slave (
    input  start, dividend_i, divisor_i,
    output quotient_o, remainder_o, ovf_o, dz_o, done, busy
  );
endinterface

// File: rtl/div_seq.sv
// Sequential signed restoring divider: a 2*WIDTH dividend divided by a WIDTH divisor.
// It produces one quotient bit per cycle, then a sign/saturation fix-up cycle.
module div_seq #(
  parameter int WIDTH = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  div_if.slave  bus
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW) + 1;

  // Largest quotient magnitudes that still fit in WIDTH signed bits.
  localparam logic [DW-1:0] NEG_LIM = DW'(1) << (WIDTH - 1);
  localparam logic [DW-1:0] POS_LIM = NEG_LIM - DW'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state;
  logic [DW-1:0]     dvd;       // shifts the dividend out and the quotient in
  logic [WIDTH:0]    rem;
  logic [WIDTH-1:0]  dsr;
  logic [WIDTH-1:0]  dvd_low;   // raw dividend low half, returned on divide-by-zero
  logic              sign_dvd;
  logic              sign_dsr;
  logic              zero_dsr;
  logic [CW-1:0]     count;

  logic [DW-1:0]     abs_dvd;
  logic [WIDTH-1:0]  abs_dsr;
  logic [WIDTH:0]    shifted;
  logic [WIDTH:0]    diff;
  logic              fits;
  logic              q_neg;
  logic              ovf_next;
  logic [WIDTH-1:0]  q_next;
  logic [WIDTH-1:0]  r_next;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    abs_dvd  = bus.dividend_i;
    abs_dsr  = bus.divisor_i;
    if (bus.dividend_i[DW-1])   abs_dvd = -bus.dividend_i;
    if (bus.divisor_i[WIDTH-1]) abs_dsr = -bus.divisor_i;

    // The partial remainder is always below |divisor|, so its top bit drops out cleanly on the shift.
    shifted  = (WIDTH+1)'({rem, dvd[DW-1]});
    diff     = shifted - {1'b0, dsr};
    fits     = (shifted >= {1'b0, dsr});

    q_neg    = sign_dvd ^ sign_dsr;
    ovf_next = q_neg ? (dvd > NEG_LIM) : (dvd > POS_LIM);

    q_next   = dvd[WIDTH-1:0];
    if (zero_dsr)      q_next = '1;
    else if (ovf_next) q_next = q_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else if (q_neg)    q_next = -dvd[WIDTH-1:0];

    r_next   = rem[WIDTH-1:0];
    if (zero_dsr)      r_next = dvd_low;
    else if (sign_dvd) r_next = -rem[WIDTH-1:0];
  end

  // NOTE: state registers use non-blocking assignments only, so every reader sees the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      dvd             <= '0;
      rem             <= '0;
      dsr             <= '0;
      dvd_low         <= '0;
      sign_dvd        <= 1'b0;
      sign_dsr        <= 1'b0;
      zero_dsr        <= 1'b0;
      count           <= '0;
      bus.quotient_o  <= '0;
      bus.remainder_o <= '0;
      bus.ovf_o       <= 1'b0;
      bus.dz_o        <= 1'b0;
      bus.done        <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            dvd      <= abs_dvd;
            dsr      <= abs_dsr;
            sign_dvd <= bus.dividend_i[DW-1];
            sign_dsr <= bus.divisor_i[WIDTH-1];
            zero_dsr <= (bus.divisor_i == '0);
            dvd_low  <= bus.dividend_i[WIDTH-1:0];
            rem      <= '0;
            count    <= '0;
            bus.busy <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          rem   <= fits ? diff : shifted;
          dvd   <= {dvd[DW-2:0], fits};
          count <= count + CW'(1);
          if (count == CW'(DW - 1)) state <= FIX;
        end
        FIX: begin
          bus.quotient_o  <= q_next;
          bus.remainder_o <= r_next;
          bus.ovf_o       <= ovf_next & ~zero_dsr;
          bus.dz_o        <= zero_dsr;
          bus.done        <= 1'b1;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq at WIDTH=16. It uses hand-computed quotients, remainders, flags and latencies.
module tb_div_seq;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  div_if #(.WIDTH(WIDTH)) bus ();

  div_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [15:0] q, input logic [15:0] r,
                           input logic ovf, input logic dz);
    check({tag, " q"},   64'(bus.quotient_o),  64'(q));
    check({tag, " r"},   64'(bus.remainder_o), 64'(r));
    check({tag, " ovf"}, 64'(bus.ovf_o),       64'(ovf));
    check({tag, " dz"},  64'(bus.dz_o),        64'(dz));
  endtask

  // Launch one operation from idle. Return the edge count from the accepting edge to done.
  task automatic run_op(input logic [31:0] a, input logic [15:0] b, output int lat);
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat;
  int gap;
  int done_seen;

  initial begin
    bus.start      = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;

    #12;
    check("reset q",    64'(bus.quotient_o),  64'd0);
    check("reset r",    64'(bus.remainder_o), 64'd0);
    check("reset flags", 64'({bus.ovf_o, bus.dz_o, bus.done, bus.busy}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'd100000, 16'd7, lat);
    check("pp latency", 64'(lat), 64'd33);
    check("pp busy at done", 64'(bus.busy), 64'd0);
    check_res("pp", 16'd14285, 16'd5, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("done one cycle", 64'(bus.done), 64'd0);

    run_op(32'(-100000), 16'd7, lat);
    check_res("np", 16'(-14285), 16'(-5), 1'b0, 1'b0);
    run_op(32'd100000, 16'(-7), lat);
    check_res("pn", 16'(-14285), 16'd5, 1'b0, 1'b0);
    run_op(32'(-100000), 16'(-7), lat);
    check_res("nn", 16'd14285, 16'(-5), 1'b0, 1'b0);

    // Overflow cases saturate, and the remainder stays exact.
    run_op(32'd1000000, 16'd3, lat);
    check_res("ovf 1e6/3", 16'd32767, 16'd1, 1'b1, 1'b0);
    run_op(32'h8000_0000, 16'hFFFF, lat);
    check_res("ovf min/-1", 16'd32767, 16'd0, 1'b1, 1'b0);
    run_op(32'h8000_0000, 16'h8000, lat);
    check_res("ovf min/-32768", 16'd32767, 16'd0, 1'b1, 1'b0);
    // 2^30 / -32768 = -32768 lands exactly on the negative limit.
    run_op(32'h4000_0000, 16'h8000, lat);
    check_res("neg limit", 16'h8000, 16'd0, 1'b0, 1'b0);

    run_op(32'd5, 16'd0, lat);
    check("dz latency", 64'(lat), 64'd33);
    check_res("dz", 16'hFFFF, 16'd5, 1'b0, 1'b1);

    // A second start while busy is ignored.
    bus.dividend_i = 32'd77;
    bus.divisor_i  = 16'd8;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    repeat (9) begin @(posedge clk); #1; lat++; end
    bus.dividend_i = 32'd9;
    bus.divisor_i  = 16'd3;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    lat++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    check("ignore latency", 64'(lat), 64'd33);
    check_res("ignore", 16'd9, 16'd5, 1'b0, 1'b0);

    // With start held high, the next operation is accepted on the edge ending the done cycle.
    bus.dividend_i = 32'd100;
    bus.divisor_i  = 16'd7;
    bus.start      = 1'b1;
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
      if (gap == 1) begin
        check("held accepted busy", 64'(bus.busy), 64'd1);
        check("held outputs kept", 64'(bus.quotient_o), 64'd9);
      end
    end while (bus.done !== 1'b1 && gap < 100);
    bus.start = 1'b0;
    check("held done gap", 64'(gap), 64'd34);
    check_res("held", 16'd14, 16'd2, 1'b0, 1'b0);

    // An asynchronous reset mid-operation aborts it without a done pulse.
    bus.dividend_i = 32'd1000;
    bus.divisor_i  = 16'd10;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort q",     64'(bus.quotient_o),  64'd0);
    check("abort r",     64'(bus.remainder_o), 64'd0);
    check("abort flags", 64'({bus.ovf_o, bus.dz_o, bus.done, bus.busy}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_seen++;
    end
    check("abort no done", 64'(done_seen), 64'd0);

    run_op(32'd6, 16'd4, lat);
    check("post reset latency", 64'(lat), 64'd33);
    check_res("post reset", 16'd1, 16'd2, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
